// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the two requester ports and the sram_driver handshake that the
//   arbiter sits between.
//   slave  : the arbiter's view (requests and driver status in; done, read
//            data, status and driver commands out).
//   master : the surrounding system's view (requesters plus the driver).
interface sram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) ();
  // requester side
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              grant;
  // sram_driver side
  logic              drv_ready;
  logic              drv_start;
  logic              drv_re;
  logic [ADDR_W-1:0] drv_address;
  logic [DATA_W-1:0] drv_wdata;
  logic [DATA_W-1:0] drv_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  drv_ready, drv_rdata,
    output done0, done1, rdata, busy, grant,
    output drv_start, drv_re, drv_address, drv_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output drv_ready, drv_rdata,
    input  done0, done1, rdata, busy, grant,
    input  drv_start, drv_re, drv_address, drv_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one sram_driver between two requesters (port 0: serial command
//   handler, port 1: pattern/test engine). Round-robin grant, sequences the
//   driver start/ready handshake and returns a done pulse plus read data to
//   the winning port.
// Ports
//   clk   : system clock
//   rstn  : asynchronous reset, active low
//   bus   : sram_arbiter_if.slave - requester ports (req/we/addr/wdata,
//           done/rdata/busy/grant) and driver ports (drv_ready, drv_start,
//           drv_re, drv_address, drv_wdata, drv_rdata)
// All outputs are registered; each output reflects the actions taken on entry
// to the current state (drv_start high during ISSUE, doneN high during RESP).
module sram_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int BUSY_WAIT = 4     // 1..15
) (
  input  logic           clk,
  input  logic           rstn,
  sram_arbiter_if.slave  bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  localparam logic [3:0] WAIT_LAST = 4'(BUSY_WAIT - 1);

  logic [2:0]        state_reg,       state_next;
  logic [3:0]        wait_cnt_reg,    wait_cnt_next;
  logic              grant_reg,       grant_next;
  logic              busy_reg,        busy_next;
  logic [1:0]        done_reg,        done_next;
  logic [DATA_W-1:0] rdata_reg,       rdata_next;
  logic              drv_start_reg,   drv_start_next;
  logic              drv_re_reg,      drv_re_next;
  logic [ADDR_W-1:0] drv_address_reg, drv_address_next;
  logic [DATA_W-1:0] drv_wdata_reg,   drv_wdata_next;

  // Per-port request view so the winner can index straight into it.
  logic [1:0]              req_vec;
  logic [1:0]              we_vec;
  logic [1:0][ADDR_W-1:0]  addr_vec;
  logic [1:0][DATA_W-1:0]  wdata_vec;

  assign req_vec   = {bus.req1,   bus.req0};
  assign we_vec    = {bus.we1,    bus.we0};
  assign addr_vec  = {bus.addr1,  bus.addr0};
  assign wdata_vec = {bus.wdata1, bus.wdata0};

  logic winner;
  logic go_resp;

  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    grant_next       = grant_reg;
    busy_next        = busy_reg;
    done_next        = 2'b00;      // doneN is a single-cycle pulse
    rdata_next       = rdata_reg;
    drv_start_next   = 1'b0;       // drv_start is a single-cycle pulse
    drv_re_next      = drv_re_reg;
    drv_address_next = drv_address_reg;
    drv_wdata_next   = drv_wdata_reg;
    go_resp          = 1'b0;
    // With both ports requesting the one not granted last time wins;
    // otherwise req1 alone decides (req1=0 means only port 0 is asking).
    winner           = (bus.req0 && bus.req1) ? ~grant_reg : bus.req1;

    case (state_reg)
      ST_IDLE: begin
        if (bus.drv_ready && (bus.req0 || bus.req1)) begin
          grant_next       = winner;
          drv_re_next      = ~we_vec[winner];
          drv_address_next = addr_vec[winner];
          drv_wdata_next   = wdata_vec[winner];
          drv_start_next   = 1'b1;
          busy_next        = 1'b1;
          state_next       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_next = 4'd0;
        state_next    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!bus.drv_ready) begin
          state_next = ST_WAIT_DONE;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          // Driver never showed busy; assume it finished instantly.
          go_resp = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.drv_ready) begin
          go_resp = 1'b1;
        end
      end
      ST_RESP: begin
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Entering RESP: raise done for the granted port and capture read data
    // so both are visible together during the RESP cycle.
    if (go_resp) begin
      state_next           = ST_RESP;
      done_next[grant_reg] = 1'b1;
      if (drv_re_reg) begin
        rdata_next = bus.drv_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= ST_IDLE;
      wait_cnt_reg    <= 4'd0;
      grant_reg       <= 1'b1;     // port 0 wins the first contention
      busy_reg        <= 1'b0;
      done_reg        <= 2'b00;
      rdata_reg       <= '0;
      drv_start_reg   <= 1'b0;
      drv_re_reg      <= 1'b0;
      drv_address_reg <= '0;
      drv_wdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      grant_reg       <= grant_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      rdata_reg       <= rdata_next;
      drv_start_reg   <= drv_start_next;
      drv_re_reg      <= drv_re_next;
      drv_address_reg <= drv_address_next;
      drv_wdata_reg   <= drv_wdata_next;
    end
  end

  assign bus.done0       = done_reg[0];
  assign bus.done1       = done_reg[1];
  assign bus.rdata       = rdata_reg;
  assign bus.busy        = busy_reg;
  assign bus.grant       = grant_reg;
  assign bus.drv_start   = drv_start_reg;
  assign bus.drv_re      = drv_re_reg;
  assign bus.drv_address = drv_address_reg;
  assign bus.drv_wdata   = drv_wdata_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Scoreboard bench for sram_arbiter. Directed stimulus pushes the expected
//   driver command and expected done response into queues; a monitor on the
//   falling edge pops and compares whenever drv_start or doneN is seen.
//   A small behavioural sram_driver model (memory + ready handshake) answers
//   the arbiter.
module tb_sram_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } issue_t;

  typedef struct packed {
    logic              port;
    logic              is_read;
    logic [DATA_W-1:0] rdata;
  } resp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUSY_WAIT(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  issue_t issue_q[$];
  resp_t  resp_q[$];

  int cyc = 0;
  int done_cnt = 0, done0_cnt = 0, done1_cnt = 0;
  int start_cnt = 0;
  int last_start_cyc = 0, last_done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- sram_driver model ----------------
  bit fast_mode = 1'b0;   // keep ready high throughout
  bit hold_low  = 1'b0;   // force ready low while idle
  int lat       = 3;      // busy length in cycles
  int rem       = 0;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] pend;

  always @(negedge clk) begin
    if (!rstn) begin
      rem           = 0;
      bus.drv_ready = !hold_low;
      bus.drv_rdata = '0;
    end else if (bus.drv_start) begin
      if (!bus.drv_re) mem[bus.drv_address] = bus.drv_wdata;
      pend = bus.drv_re ? mem[bus.drv_address] : '0;
      if (fast_mode) begin
        bus.drv_rdata = pend;
      end else begin
        bus.drv_ready = 1'b0;
        rem           = lat;
      end
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        bus.drv_ready = 1'b1;
        bus.drv_rdata = pend;
      end
    end else begin
      bus.drv_ready = !hold_low;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_start = 1'b0;
  logic prev_done  = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_start = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (bus.drv_start) begin
        issue_t ei;
        start_cnt++;
        last_start_cyc = cyc;
        check("start_single_cycle", {31'd0, prev_start}, 32'd0);
        if (issue_q.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          ei = issue_q.pop_front();
          check("issue_re",   {31'd0, bus.drv_re}, {31'd0, ei.re});
          check("issue_addr", {19'd0, bus.drv_address}, {19'd0, ei.addr});
          check("issue_data", {24'd0, bus.drv_wdata}, {24'd0, ei.wdata});
        end
      end
      prev_start = bus.drv_start;

      if (bus.done0 || bus.done1) begin
        resp_t er;
        done_cnt++;
        if (bus.done0) done0_cnt++;
        if (bus.done1) done1_cnt++;
        last_done_cyc = cyc;
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        check("busy_in_resp", {31'd0, bus.busy}, 32'd1);
        if (resp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          er = resp_q.pop_front();
          check("done_ports", {30'd0, bus.done1, bus.done0},
                er.port ? 32'd2 : 32'd1);
          check("grant", {31'd0, bus.grant}, {31'd0, er.port});
          if (er.is_read) check("rdata", {24'd0, bus.rdata}, {24'd0, er.rdata});
        end
      end
      prev_done = bus.done0 | bus.done1;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_done(input string name, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic wait_start(input string name, input int target, input int budget);
    int n = 0;
    while (start_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, {31'd0, start_cnt >= target}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, s, rel_cyc;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_drv_start", {31'd0, bus.drv_start}, 32'd0);
    check("rst_busy",      {31'd0, bus.busy}, 32'd0);
    check("rst_done",      {30'd0, bus.done1, bus.done0}, 32'd0);
    check("rst_rdata",     {24'd0, bus.rdata}, 32'd0);
    check("rst_grant",     {31'd0, bus.grant}, 32'd1);
    check("rst_drv_addr",  {19'd0, bus.drv_address}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1. single write on port 0
    issue_q.push_back('{re: 1'b0, addr: 13'h0155, wdata: 8'hA5});
    resp_q.push_back('{port: 1'b0, is_read: 1'b0, rdata: 8'h00});
    bus.we0 = 1; bus.addr0 = 13'h0155; bus.wdata0 = 8'hA5; bus.req0 = 1;
    wait_done("t1_done_seen", 1, 50);
    bus.req0 = 0;
    @(negedge clk); #1;
    check("t1_busy_dropped", {31'd0, bus.busy}, 32'd0);
    check("t1_done_cleared", {30'd0, bus.done1, bus.done0}, 32'd0);
    check("t1_one_start", start_cnt, 32'd1);
    check("t1_no_done1", done1_cnt, 32'd0);

    // 2. read back on port 1
    issue_q.push_back('{re: 1'b1, addr: 13'h0155, wdata: 8'h3C});
    resp_q.push_back('{port: 1'b1, is_read: 1'b1, rdata: 8'hA5});
    bus.we1 = 0; bus.addr1 = 13'h0155; bus.wdata1 = 8'h3C; bus.req1 = 1;
    wait_done("t2_done_seen", 2, 50);
    bus.req1 = 0;
    repeat (10) @(negedge clk);
    #1;
    check("t2_rdata_held", {24'd0, bus.rdata}, 32'h0000_00A5);
    check("t2_grant_held", {31'd0, bus.grant}, 32'd1);

    // 3. contention from reset: 0,1,0,1
    do_reset();
    base = done_cnt;
    s    = done0_cnt;
    bus.we0 = 1; bus.addr0 = 13'h0010; bus.wdata0 = 8'h11;
    bus.we1 = 1; bus.addr1 = 13'h0020; bus.wdata1 = 8'h22;
    for (int i = 0; i < 2; i++) begin
      issue_q.push_back('{re: 1'b0, addr: 13'h0010, wdata: 8'h11});
      resp_q.push_back('{port: 1'b0, is_read: 1'b0, rdata: 8'h00});
      issue_q.push_back('{re: 1'b0, addr: 13'h0020, wdata: 8'h22});
      resp_q.push_back('{port: 1'b1, is_read: 1'b0, rdata: 8'h00});
    end
    bus.req0 = 1; bus.req1 = 1;
    wait_done("t3_four_done", base + 4, 200);
    bus.req0 = 0; bus.req1 = 0;
    repeat (10) @(negedge clk);
    #1;
    check("t3_no_extra_done", done_cnt - base, 32'd4);
    check("t3_two_done0", done0_cnt - s, 32'd2);
    check("t3_two_done1", done1_cnt, 32'd3);   // 1 from test 2 plus 2 here

    // 4. fast driver: ready never drops
    fast_mode = 1'b1;
    repeat (2) @(negedge clk);
    issue_q.push_back('{re: 1'b0, addr: 13'h00AA, wdata: 8'h5A});
    resp_q.push_back('{port: 1'b0, is_read: 1'b0, rdata: 8'h00});
    bus.we0 = 1; bus.addr0 = 13'h00AA; bus.wdata0 = 8'h5A; bus.req0 = 1;
    wait_done("t4_done_seen", done_cnt + 1, 50);
    bus.req0 = 0;
    check("t4_start_to_done", last_done_cyc - last_start_cyc, 32'd5);
    fast_mode = 1'b0;
    repeat (3) @(negedge clk);

    // 5. reset during WAIT_DONE
    lat  = 12;
    base = done_cnt;
    issue_q.push_back('{re: 1'b0, addr: 13'h0077, wdata: 8'h99});
    bus.we0 = 1; bus.addr0 = 13'h0077; bus.wdata0 = 8'h99; bus.req0 = 1;
    wait_start("t5_start_seen", start_cnt + 1, 50);
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    bus.req0 = 0;
    #1;
    check("t5_rst_drv_start", {31'd0, bus.drv_start}, 32'd0);
    check("t5_rst_busy",      {31'd0, bus.busy}, 32'd0);
    check("t5_rst_done",      {30'd0, bus.done1, bus.done0}, 32'd0);
    check("t5_rst_grant",     {31'd0, bus.grant}, 32'd1);
    check("t5_rst_drv_addr",  {19'd0, bus.drv_address}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    lat  = 3;
    repeat (15) @(negedge clk);
    #1;
    check("t5_no_done_after_abort", done_cnt - base, 32'd0);
    issue_q.push_back('{re: 1'b0, addr: 13'h0078, wdata: 8'h66});
    resp_q.push_back('{port: 1'b0, is_read: 1'b0, rdata: 8'h00});
    bus.we0 = 1; bus.addr0 = 13'h0078; bus.wdata0 = 8'h66; bus.req0 = 1;
    wait_done("t5_recovered", base + 1, 50);
    bus.req0 = 0;
    repeat (3) @(negedge clk);

    // 6. drv_ready low in IDLE blocks the start
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    s = start_cnt;
    bus.we0 = 1; bus.addr0 = 13'h0100; bus.wdata0 = 8'h42; bus.req0 = 1;
    repeat (8) @(negedge clk);
    #1;
    check("t6_no_start_while_not_ready", start_cnt - s, 32'd0);
    issue_q.push_back('{re: 1'b0, addr: 13'h0100, wdata: 8'h42});
    resp_q.push_back('{port: 1'b0, is_read: 1'b0, rdata: 8'h00});
    rel_cyc  = cyc;
    hold_low = 1'b0;
    wait_done("t6_done_after_ready", done_cnt + 1, 50);
    bus.req0 = 0;
    check("t6_start_after_release", {31'd0, last_start_cyc > rel_cyc}, 32'd1);
    repeat (5) @(negedge clk);

    check("issue_queue_empty", issue_q.size(), 32'd0);
    check("resp_queue_empty",  resp_q.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
